// File: rtl/mem_arbiter_rr_if.sv
// mem_arbiter_rr_if: channel-side and memory-side signals of the
// line arbiter; slave is the arbiter view, master the environment view.
interface mem_arbiter_rr_if #(
    parameter int NUM_CH = 2,
    parameter int LINE_W = 128,
    parameter int ADDR_W = 16
);
    logic [NUM_CH-1:0]        ch_read;
    logic [NUM_CH-1:0]        ch_write;
    logic [NUM_CH*ADDR_W-1:0] ch_address;
    logic [NUM_CH*LINE_W-1:0] ch_wdata;
    logic [LINE_W-1:0]        ch_rdata;
    logic [NUM_CH-1:0]        ch_resp;
    logic                     pmem_resp;
    logic [LINE_W-1:0]        pmem_rdata;
    logic                     pmem_read;
    logic                     pmem_write;
    logic [ADDR_W-1:0]        pmem_address;
    logic [LINE_W-1:0]        pmem_wdata;

    modport slave (
        input  ch_read, ch_write, ch_address, ch_wdata,
        input  pmem_resp, pmem_rdata,
        output ch_rdata, ch_resp,
        output pmem_read, pmem_write, pmem_address, pmem_wdata
    );

    modport master (
        output ch_read, ch_write, ch_address, ch_wdata,
        output pmem_resp, pmem_rdata,
        input  ch_rdata, ch_resp,
        input  pmem_read, pmem_write, pmem_address, pmem_wdata
    );
endinterface

// File: rtl/mem_arbiter_rr.sv
// mem_arbiter_rr: NUM_CH cache channels share one memory port, one line
// transaction at a time, round-robin or fixed-priority arbitration.
module mem_arbiter_rr #(
    parameter int NUM_CH     = 2,
    parameter int LINE_W     = 128,
    parameter int ADDR_W     = 16,
    parameter bit FIXED_PRIO = 1'b0
) (
    input logic             clk,
    input logic             reset_n,
    mem_arbiter_rr_if.slave bus
);
    localparam int IDX_W = $clog2(NUM_CH);
    localparam logic [IDX_W:0] NCH = (IDX_W+1)'(NUM_CH);
    localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_CH-1);
    localparam logic [NUM_CH-1:0] ONE = NUM_CH'(1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t state, state_nx;

    logic [IDX_W-1:0]  ptr, ptr_nx;
    logic [IDX_W-1:0]  gnt, pick;
    logic [IDX_W:0]    idx;
    logic              found;
    logic              grant, hit, busy;
    logic [NUM_CH-1:0] req;
    logic              op_wr;
    logic [ADDR_W-1:0] addr;
    logic [LINE_W-1:0] wdata;

    assign req = bus.ch_read | bus.ch_write;

    // search upward from ptr (or from 0 in fixed mode), wrapping
    always_comb begin
        found = 1'b0;
        pick  = '0;
        idx   = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            idx = (IDX_W+1)'(k);
            if (!FIXED_PRIO)
                idx = idx + {1'b0, ptr};
            if (idx >= NCH)
                idx = idx - NCH;
            if (!found && req[idx[IDX_W-1:0]]) begin
                found = 1'b1;
                pick  = idx[IDX_W-1:0];
            end
        end
    end

    always_comb begin
        state_nx = state;
        grant    = 1'b0;
        hit      = 1'b0;
        unique case (state)
            IDLE: if (found) begin
                grant    = 1'b1;
                state_nx = BUSY;
            end
            BUSY: if (bus.pmem_resp) begin
                hit      = 1'b1;
                state_nx = DONE;
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        ptr_nx = ptr;
        if (grant && !FIXED_PRIO)
            ptr_nx = (pick == LAST) ? '0 : pick + IDX_W'(1);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            ptr   <= '0;
            gnt   <= '0;
            op_wr <= 1'b0;
            addr  <= '0;
            wdata <= '0;
        end else begin
            state <= state_nx;
            ptr   <= ptr_nx;
            if (grant) begin
                gnt   <= pick;
                op_wr <= bus.ch_write[pick];
                addr  <= bus.ch_address[pick*ADDR_W +: ADDR_W];
                wdata <= bus.ch_wdata[pick*LINE_W +: LINE_W];
            end
        end
    end

    // memory side is driven only from the registered request
    assign busy             = (state == BUSY);
    assign bus.pmem_read    = busy & ~op_wr;
    assign bus.pmem_write   = busy & op_wr;
    assign bus.pmem_address = busy ? addr : '0;
    assign bus.pmem_wdata   = busy ? wdata : '0;
    assign bus.ch_resp      = hit ? (ONE << gnt) : '0;
    assign bus.ch_rdata     = hit ? bus.pmem_rdata : '0;
endmodule
